// File: rtl/key_event_tracker.sv
// Keyboard front-end: matches HID usage codes in a multi-slot keycode word, debounces each key
// on frame ticks and produces registered level, press, release and auto-repeat outputs.
module key_event_tracker #(
  parameter int SLOTS         = 4,
  parameter int KEY_W         = 8,
  parameter int NUM_KEYS      = 7,
  parameter logic [NUM_KEYS*KEY_W-1:0] KEY_CODES =
    {8'h28, 8'h0B, 8'h2C, 8'h07, 8'h16, 8'h04, 8'h1A},
  parameter int DEBOUNCE      = 2,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   tick,
  input  logic [SLOTS*KEY_W-1:0] keycode,
  output logic [NUM_KEYS-1:0]    key_held,
  output logic [NUM_KEYS-1:0]    key_press,
  output logic [NUM_KEYS-1:0]    key_release,
  output logic [NUM_KEYS-1:0]    key_repeat,
  output logic                   any_held,
  output logic                   rollover_err
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int RP_W = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam logic [KEY_W-1:0] ROLLOVER_CODE = {{(KEY_W-1){1'b0}}, 1'b1};
  localparam logic [DB_W-1:0]  DB_TARGET     = DB_W'(DEBOUNCE);
  localparam logic [RP_W-1:0]  RP_DELAY      = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0]  RP_RELOAD     =
    (REPEAT_DELAY >= REPEAT_PERIOD) ? RP_W'(REPEAT_DELAY - REPEAT_PERIOD) : {RP_W{1'b0}};

  logic [NUM_KEYS-1:0] raw_s;
  logic                rollover_s;

  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;
  logic                any_held_q, any_held_d;
  logic                rollover_q, rollover_d;
  logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
  logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];
  logic [RP_W-1:0]     rp_cnt_q [NUM_KEYS];
  logic [RP_W-1:0]     rp_cnt_d [NUM_KEYS];

  // Code 0 marks an unused key entry, so it must never match an empty slot.
  always_comb begin
    raw_s      = {NUM_KEYS{1'b0}};
    rollover_s = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      rollover_s = rollover_s | (keycode[s*KEY_W +: KEY_W] == ROLLOVER_CODE);
      for (int k = 0; k < NUM_KEYS; k++) begin
        raw_s[k] = raw_s[k] |
                   ((KEY_CODES[k*KEY_W +: KEY_W] != {KEY_W{1'b0}}) &&
                    (keycode[s*KEY_W +: KEY_W] == KEY_CODES[k*KEY_W +: KEY_W]));
      end
    end
  end

  always_comb begin
    logic [DB_W-1:0] db_inc;
    logic [RP_W-1:0] rp_inc;
    held_d     = held_q;
    press_d    = {NUM_KEYS{1'b0}};
    release_d  = {NUM_KEYS{1'b0}};
    repeat_d   = {NUM_KEYS{1'b0}};
    rollover_d = rollover_q;
    db_cnt_d   = db_cnt_q;
    rp_cnt_d   = rp_cnt_q;
    db_inc     = {DB_W{1'b0}};
    rp_inc     = {RP_W{1'b0}};
    if (tick) begin
      rollover_d = rollover_s;
      if (!rollover_s) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
          db_inc = db_cnt_q[k] + 1'b1;
          if (raw_s[k] == held_q[k]) begin
            db_cnt_d[k] = {DB_W{1'b0}};
          end else if (db_inc == DB_TARGET) begin
            held_d[k]    = raw_s[k];
            db_cnt_d[k]  = {DB_W{1'b0}};
            press_d[k]   = raw_s[k];
            release_d[k] = ~raw_s[k];
          end else begin
            db_cnt_d[k] = db_inc;
          end

          // The press tick is count 0, so a repeat can never share a cycle with a press.
          if (!held_d[k] || !held_q[k] || (REPEAT_DELAY == 0)) begin
            rp_cnt_d[k] = {RP_W{1'b0}};
          end else begin
            rp_inc = (rp_cnt_q[k] == {RP_W{1'b1}}) ? rp_cnt_q[k] : rp_cnt_q[k] + 1'b1;
            if (rp_inc == RP_DELAY) begin
              repeat_d[k] = 1'b1;
              rp_cnt_d[k] = RP_RELOAD;
            end else begin
              rp_cnt_d[k] = rp_inc;
            end
          end
        end
      end else begin
        rollover_d = 1'b1;
      end
    end else begin
      rollover_d = rollover_q;
    end
    any_held_d = |held_d;
  end

  // State and registered outputs; reset wins over a coincident tick.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      held_q     <= {NUM_KEYS{1'b0}};
      press_q    <= {NUM_KEYS{1'b0}};
      release_q  <= {NUM_KEYS{1'b0}};
      repeat_q   <= {NUM_KEYS{1'b0}};
      any_held_q <= 1'b0;
      rollover_q <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        db_cnt_q[k] <= {DB_W{1'b0}};
        rp_cnt_q[k] <= {RP_W{1'b0}};
      end
    end else begin
      held_q     <= held_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      any_held_q <= any_held_d;
      rollover_q <= rollover_d;
      db_cnt_q   <= db_cnt_d;
      rp_cnt_q   <= rp_cnt_d;
    end
  end

  assign key_held     = held_q;
  assign key_press    = press_q;
  assign key_release  = release_q;
  assign key_repeat   = repeat_q;
  assign any_held     = any_held_q;
  assign rollover_err = rollover_q;

endmodule

// File: tb/tb_key_event_tracker.sv
// Directed bench for key_event_tracker: default build plus a REPEAT_DELAY=0 build on shared inputs.
module tb_key_event_tracker;

  logic        Clk;
  logic        Reset_n;
  logic        tick;
  logic [31:0] keycode;
  logic [6:0]  key_held, key_press, key_release, key_repeat;
  logic        any_held, rollover_err;
  logic [6:0]  nr_held, nr_press, nr_release, nr_repeat;
  logic        nr_any_held, nr_rollover_err;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] W_KEY = 32'h1A000000;

  key_event_tracker dut (
    .Clk(Clk), .Reset_n(Reset_n), .tick(tick), .keycode(keycode),
    .key_held(key_held), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .any_held(any_held), .rollover_err(rollover_err)
  );

  key_event_tracker #(.REPEAT_DELAY(0)) dut_norep (
    .Clk(Clk), .Reset_n(Reset_n), .tick(tick), .keycode(keycode),
    .key_held(nr_held), .key_press(nr_press), .key_release(nr_release),
    .key_repeat(nr_repeat), .any_held(nr_any_held), .rollover_err(nr_rollover_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One tick cycle; outputs are sampled by the caller at the following negedge.
  task automatic do_tick(input logic [31:0] kc);
    @(negedge Clk);
    keycode = kc;
    tick    = 1'b1;
    @(negedge Clk);
    tick    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_held"},    {25'd0, key_held},    32'd0);
    chk({tag, "_press"},   {25'd0, key_press},   32'd0);
    chk({tag, "_release"}, {25'd0, key_release}, 32'd0);
    chk({tag, "_repeat"},  {25'd0, key_repeat},  32'd0);
    chk({tag, "_any"},     {31'd0, any_held},    32'd0);
    chk({tag, "_roll"},    {31'd0, rollover_err}, 32'd0);
  endtask

  initial begin
    logic exp_rep;
    Reset_n = 1'b0;
    tick    = 1'b0;
    keycode = 32'h0;

    // 1: reset with keys present and tick pulsing, then W+A accepted after two ticks
    repeat (3) do_tick(32'h1A040000);
    chk_all_zero("t1_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    do_tick(32'h1A040000);
    chk("t1_held_after1", {25'd0, key_held}, 32'h00);
    chk("t1_press_after1", {25'd0, key_press}, 32'h00);
    do_tick(32'h1A040000);
    chk("t1_press", {25'd0, key_press}, 32'h03);
    chk("t1_held", {25'd0, key_held}, 32'h03);
    chk("t1_any", {31'd0, any_held}, 32'h1);
    @(negedge Clk);
    chk("t1_press_width", {25'd0, key_press}, 32'h00);
    do_tick(32'h0);
    chk("t1_rel_after1", {25'd0, key_release}, 32'h00);
    do_tick(32'h0);
    chk("t1_release", {25'd0, key_release}, 32'h03);
    chk("t1_held_clr", {25'd0, key_held}, 32'h00);

    // 2: single-tick glitch is rejected, two-tick hold is accepted
    do_tick(W_KEY);
    chk("t2_glitch_press", {25'd0, key_press}, 32'h00);
    do_tick(32'h0);
    chk("t2_glitch_held", {25'd0, key_held}, 32'h00);
    chk("t2_glitch_press2", {25'd0, key_press}, 32'h00);
    do_tick(W_KEY);
    chk("t2_held_after1", {25'd0, key_held}, 32'h00);
    do_tick(W_KEY);
    chk("t2_press", {25'd0, key_press}, 32'h01);
    chk("t2_held", {25'd0, key_held}, 32'h01);

    // 3: repeats at 30,36,42,48,54 ticks after the press; none during release
    for (int i = 1; i <= 56; i++) begin
      do_tick(W_KEY);
      exp_rep = (i == 30) || (i == 36) || (i == 42) || (i == 48) || (i == 54);
      chk($sformatf("t3_repeat_%0d", i), {25'd0, key_repeat}, {31'd0, exp_rep});
      chk($sformatf("t3_norep_%0d", i), {25'd0, nr_repeat}, 32'h00);
    end
    chk("t3_norep_held", {25'd0, nr_held}, 32'h01);
    do_tick(32'h0);
    chk("t3_rel_after1", {25'd0, key_release}, 32'h00);
    chk("t3_rep_rel1", {25'd0, key_repeat}, 32'h00);
    chk("t3_held_rel1", {25'd0, key_held}, 32'h01);
    do_tick(32'h0);
    chk("t3_release", {25'd0, key_release}, 32'h01);
    chk("t3_rep_rel2", {25'd0, key_repeat}, 32'h00);
    chk("t3_held_rel2", {25'd0, key_held}, 32'h00);
    do_tick(32'h0);
    chk("t3_rep_after", {25'd0, key_repeat}, 32'h00);

    // 4: duplicate codes count once; rollover frames freeze state
    do_tick(32'h1A1A1A1A);
    do_tick(32'h1A1A1A1A);
    chk("t4_dup_press", {25'd0, key_press}, 32'h01);
    do_tick(32'h01010101);
    chk("t4_roll", {31'd0, rollover_err}, 32'h1);
    chk("t4_roll_held", {25'd0, key_held}, 32'h01);
    chk("t4_roll_rel", {25'd0, key_release}, 32'h00);
    @(negedge Clk);
    chk("t4_roll_persist", {31'd0, rollover_err}, 32'h1);
    do_tick(32'h00000001);
    chk("t4_roll2_held", {25'd0, key_held}, 32'h01);
    chk("t4_roll2_rel", {25'd0, key_release}, 32'h00);
    do_tick(32'h0);
    chk("t4_roll_clr", {31'd0, rollover_err}, 32'h0);
    chk("t4_held_after1", {25'd0, key_held}, 32'h01);
    do_tick(32'h0);
    chk("t4_release", {25'd0, key_release}, 32'h01);
    chk("t4_held_clr", {25'd0, key_held}, 32'h00);

    // 5: enter, space, d, h pressed together
    do_tick(32'h282C070B);
    do_tick(32'h282C070B);
    chk("t5_press", {25'd0, key_press}, 32'h78);
    chk("t5_held", {25'd0, key_held}, 32'h78);
    chk("t5_any", {31'd0, any_held}, 32'h1);
    do_tick(32'h0);
    do_tick(32'h0);
    chk("t5_release", {25'd0, key_release}, 32'h78);
    chk("t5_any_clr", {31'd0, any_held}, 32'h0);

    // 6: reset while W is held past its first repeat, coincident with a tick
    do_tick(W_KEY);
    do_tick(W_KEY);
    chk("t6_press", {25'd0, key_press}, 32'h01);
    repeat (32) do_tick(W_KEY);
    chk("t6_held_pre", {25'd0, key_held}, 32'h01);
    @(negedge Clk);
    Reset_n = 1'b0;
    tick    = 1'b1;
    keycode = 32'h0;
    @(negedge Clk);
    tick    = 1'b0;
    chk_all_zero("t6_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    do_tick(32'h0);
    chk("t6_no_rel1", {25'd0, key_release}, 32'h00);
    do_tick(32'h0);
    chk("t6_no_rel2", {25'd0, key_release}, 32'h00);
    chk("t6_held", {25'd0, key_held}, 32'h00);
    do_tick(W_KEY);
    do_tick(W_KEY);
    chk("t6_repress", {25'd0, key_press}, 32'h01);
    for (int i = 1; i <= 30; i++) begin
      do_tick(W_KEY);
      chk($sformatf("t6_repeat_%0d", i), {25'd0, key_repeat}, {31'd0, (i == 30)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
